// File: rtl/bcd_add_sequencer.sv
// Feeds BCD operand digits, least significant first, to an external serial BCD adder and assembles the sum.
// Optional operand validation is enabled by defining BCD_SEQ_CHECK_EN.
module bcd_add_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DIGITS-1:0]       op_a,
    input  logic [4*DIGITS-1:0]       op_b,
    output logic [3:0]                dig_a,
    output logic [3:0]                dig_b,
    output logic                      add_start,
    output logic                      add_done,
    input  logic [3:0]                add_sum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*(DIGITS+1)-1:0]   result,
    output logic                      err
);

    typedef enum logic [2:0] {IDLE, RUN, CARRY, FLUSH, RESP} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 idx_q, idx_d;
    logic [4*DIGITS-1:0]        a_q, a_d, b_q, b_d;
    logic [4*(DIGITS+1)-1:0]    result_q, result_d;
    logic                       err_q, err_d;
    logic                       bad_ops;

`ifdef BCD_SEQ_CHECK_EN
    logic [2*DIGITS-1:0] nib_bad;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign nib_bad[2*gi]   = (op_a[4*gi +: 4] > 4'd9);
            assign nib_bad[2*gi+1] = (op_b[4*gi +: 4] > 4'd9);
        end
    endgenerate
    assign bad_ops = |nib_bad;
`else
    assign bad_ops = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        dig_a     = 4'd0;
        dig_b     = 4'd0;
        add_start = 1'b0;
        add_done  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    result_d = '0;
                    idx_d    = '0;
                    // Invalid operands skip the adder entirely and report at once
                    if (bad_ops) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dig_a     = a_q[idx_q*4 +: 4];
                dig_b     = b_q[idx_q*4 +: 4];
                add_start = (idx_q == 4'd0);
                result_d[idx_q*4 +: 4] = add_sum;
                if (idx_q == 4'(DIGITS-1)) begin
                    idx_d   = '0;
                    state_d = CARRY;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            CARRY: begin
                // Zero digits let the adder emit its pending carry as the top digit
                result_d[4*DIGITS +: 4] = add_sum;
                state_d = FLUSH;
            end
            FLUSH: begin
                add_done = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer: behavioural serial BCD adder, vector table and scoreboard.
module tb_bcd_add_sequencer;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [3:0]  dig_a, dig_b;
    logic        add_start, add_done;
    logic [3:0]  add_sum;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] result;
    logic        err;

    bcd_add_sequencer #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .dig_a(dig_a), .dig_b(dig_b),
        .add_start(add_start), .add_done(add_done),
        .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // Serial BCD adder: carry forced to 0 on add_start, cleared by add_done
    logic       carry_q;
    logic [4:0] raw;
    logic       cout;
    always_comb begin
        raw     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, (add_start ? 1'b0 : carry_q)};
        cout    = (raw > 5'd9);
        add_sum = cout ? 4'(raw - 5'd10) : raw[3:0];
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn) carry_q <= 1'b0;
        else       carry_q <= add_done ? 1'b0 : cout;
    end

    int n_start = 0;
    int n_done  = 0;
    always @(posedge clk) begin
        if (add_start) n_start <= n_start + 1;
        if (add_done)  n_done  <= n_done + 1;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] res;
        logic        err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [19:0] res;
        logic        err;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   k;
        int   lat;
        int   s0;
        int   d0;
        exp_t e;
        s0 = n_start;
        d0 = n_done;
        out_ready = (v.hold == 0);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        op_a = v.a;
        op_b = v.b;
        @(posedge clk);
        e.res = v.res;
        e.err = v.err;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        @(negedge clk);
        if (!v.err) begin
            check("first_add_start", add_start, 1);
            check("first_dig_a", dig_a, v.a[3:0]);
            check("first_dig_b", dig_b, v.b[3:0]);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, v.err ? 0 : DIGITS + 2);
        for (int h = 0; h < v.hold; h++) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, v.res);
            check("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            $display("txn a=%04h b=%04h -> result=%05h err=%0d (exp %05h/%0d)",
                     v.a, v.b, result, err, e.res, e.err);
            check("result", result, e.res);
            check("err", err, e.err);
        end else begin
            check("out_valid_present", out_valid, 1);
        end
        check("in_ready_resp", in_ready, 0);
        @(negedge clk);
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
        check("start_pulses", n_start - s0, v.err ? 0 : 1);
        check("done_pulses", n_done - d0, v.err ? 0 : 1);
    endtask

    initial begin
        int bad;
        vecs[0] = '{16'h0123, 16'h0480, 20'h00603, 1'b0, 5};
        vecs[1] = '{16'h9999, 16'h0001, 20'h10000, 1'b0, 0};
        vecs[2] = '{16'h0000, 16'h0000, 20'h00000, 1'b0, 0};
        vecs[3] = '{16'h0005, 16'h0005, 20'h00010, 1'b0, 0};
        vecs[4] = '{16'h4567, 16'h5678, 20'h10245, 1'b0, 0};
        vecs[5] = '{16'h9999, 16'h9999, 20'h19998, 1'b0, 2};
        vecs[6] = '{16'h0050, 16'h0049, 20'h00099, 1'b0, 0};
`ifdef BCD_SEQ_CHECK_EN
        vecs[7] = '{16'h00A0, 16'h0000, 20'h00000, 1'b1, 0};
`else
        vecs[7] = '{16'h00A0, 16'h0000, 20'h00100, 1'b0, 0};
`endif

        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_add_done", add_done, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of RUN digit 2
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op_a = 16'h1234;
        op_b = 16'h1111;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_dig_a", dig_a, 4'h2);
        check("mid_dig_b", dig_b, 4'h1);
        #2 rstn = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_result", result, 0);
        check("mrst_dig_a", dig_a, 0);
        check("mrst_dig_b", dig_b, 0);
        check("mrst_add_start", add_start, 0);
        check("mrst_add_done", add_done, 0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_partial_result", bad, 0);
        run_vec(vecs[4]);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
